// File: rtl/uart_loader.sv
// Byte-stream program loader: parses I/D/R command packets from a UART receiver
// and emits word writes into instruction or data memory, plus a core run enable.
module uart_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        insn_we,
  output logic [31:0] insn_addr,
  output logic [31:0] insn_din,
  output logic        data_we,
  output logic [31:0] data_addr,
  output logic [31:0] data_din,
  output logic        run,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ADDR, LEN, DATA} state_e;

  localparam logic [7:0] CMD_INSN = 8'h49;
  localparam logic [7:0] CMD_DATA = 8'h44;
  localparam logic [7:0] CMD_RUN  = 8'h52;

  state_e      state_q, state_d;
  logic        target_data_q, target_data_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] base_q, base_d;
  logic [15:0] count_q, count_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [23:0] word_buf_q, word_buf_d;
  logic [31:0] gap_q, gap_d;

  logic        insn_we_q, insn_we_d;
  logic [31:0] insn_addr_q, insn_addr_d;
  logic [31:0] insn_din_q, insn_din_d;
  logic        data_we_q, data_we_d;
  logic [31:0] data_addr_q, data_addr_d;
  logic [31:0] data_din_q, data_din_d;
  logic        run_q, run_d;
  logic        err_q, err_d;

  logic        timeout;
  logic [15:0] len_full;
  logic [31:0] word_full;
  logic [31:0] word_addr;

  assign timeout   = (state_q != IDLE) && (gap_q == TIMEOUT_CYCLES);
  assign len_full  = {rx_data, count_q[15:8]};
  assign word_full = {rx_data, word_buf_q};
  assign word_addr = base_q + {14'd0, word_cnt_q, 2'b00};

  always_comb begin
    // NOTE: every _d gets a default here so no path through the case below
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    target_data_d = target_data_q;
    byte_cnt_d    = byte_cnt_q;
    base_d        = base_q;
    count_d       = count_q;
    word_cnt_d    = word_cnt_q;
    word_buf_d    = word_buf_q;
    insn_we_d     = 1'b0;
    insn_addr_d   = insn_addr_q;
    insn_din_d    = insn_din_q;
    data_we_d     = 1'b0;
    data_addr_d   = data_addr_q;
    data_din_d    = data_din_q;
    run_d         = run_q;
    err_d         = 1'b0;
    gap_d         = (state_q == IDLE || rx_valid) ? 32'd0 : gap_q + 32'd1;

    if (timeout) begin
      // The byte arriving on this cycle is dropped along with the partial word.
      state_d    = IDLE;
      err_d      = 1'b1;
      byte_cnt_d = 2'd0;
      gap_d      = 32'd0;
    end else if (rx_valid) begin
      unique case (state_q)
        IDLE: begin
          byte_cnt_d = 2'd0;
          if (rx_data == CMD_INSN || rx_data == CMD_DATA) begin
            target_data_d = (rx_data == CMD_DATA);
            run_d         = 1'b0;
            state_d       = ADDR;
          end else if (rx_data == CMD_RUN) begin
            run_d = 1'b1;
          end
        end
        ADDR: begin
          base_d     = {rx_data, base_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = LEN;
        end
        LEN: begin
          count_d = len_full;
          if (byte_cnt_q[0]) begin
            byte_cnt_d = 2'd0;
            word_cnt_d = 16'd0;
            state_d    = (len_full == 16'd0) ? IDLE : DATA;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
        DATA: begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (target_data_q) begin
              data_we_d   = 1'b1;
              data_addr_d = word_addr;
              data_din_d  = word_full;
            end else begin
              insn_we_d   = 1'b1;
              insn_addr_d = word_addr;
              insn_din_d  = word_full;
            end
            word_cnt_d = word_cnt_q + 16'd1;
            if (word_cnt_q + 16'd1 == count_q) state_d = IDLE;
          end else begin
            word_buf_d = {rx_data, word_buf_q[23:8]};
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      target_data_q <= 1'b0;
      byte_cnt_q    <= 2'd0;
      base_q        <= 32'd0;
      count_q       <= 16'd0;
      word_cnt_q    <= 16'd0;
      word_buf_q    <= 24'd0;
      gap_q         <= 32'd0;
      insn_we_q     <= 1'b0;
      insn_addr_q   <= 32'd0;
      insn_din_q    <= 32'd0;
      data_we_q     <= 1'b0;
      data_addr_q   <= 32'd0;
      data_din_q    <= 32'd0;
      run_q         <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_data_q <= target_data_d;
      byte_cnt_q    <= byte_cnt_d;
      base_q        <= base_d;
      count_q       <= count_d;
      word_cnt_q    <= word_cnt_d;
      word_buf_q    <= word_buf_d;
      gap_q         <= gap_d;
      insn_we_q     <= insn_we_d;
      insn_addr_q   <= insn_addr_d;
      insn_din_q    <= insn_din_d;
      data_we_q     <= data_we_d;
      data_addr_q   <= data_addr_d;
      data_din_q    <= data_din_d;
      run_q         <= run_d;
      err_q         <= err_d;
    end
  end

  assign insn_we   = insn_we_q;
  assign insn_addr = insn_addr_q;
  assign insn_din  = insn_din_q;
  assign data_we   = data_we_q;
  assign data_addr = data_addr_q;
  assign data_din  = data_din_q;
  assign run       = run_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_uart_loader.sv
// Directed self-checking bench for uart_loader, built with a short idle-gap limit.
module tb_uart_loader;

  logic        clk;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        insn_we;
  logic [31:0] insn_addr;
  logic [31:0] insn_din;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_din;
  logic        run;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  // Write/err log captured at the falling edge.
  logic [31:0] ins_a [16];
  logic [31:0] ins_d [16];
  logic [31:0] dat_a [16];
  logic [31:0] dat_d [16];
  int n_ins = 0;
  int n_dat = 0;
  int n_err = 0;

  logic [7:0] pkt [$];

  uart_loader #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .insn_we   (insn_we),
    .insn_addr (insn_addr),
    .insn_din  (insn_din),
    .data_we   (data_we),
    .data_addr (data_addr),
    .data_din  (data_din),
    .run       (run),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (insn_we && n_ins < 16) begin
      ins_a[n_ins] <= insn_addr;
      ins_d[n_ins] <= insn_din;
    end
    if (data_we && n_dat < 16) begin
      dat_a[n_dat] <= data_addr;
      dat_d[n_dat] <= data_din;
    end
    if (insn_we) n_ins <= n_ins + 1;
    if (data_we) n_dat <= n_dat + 1;
    if (err)     n_err <= n_err + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_pkt(input int gap);
    foreach (pkt[i]) begin
      send_byte(pkt[i]);
      if (gap > 0 && i != pkt.size() - 1) idle(gap);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " insn_we"},   {31'd0, insn_we}, 32'd0);
    check({tag, " data_we"},   {31'd0, data_we}, 32'd0);
    check({tag, " run"},       {31'd0, run},     32'd0);
    check({tag, " busy"},      {31'd0, busy},    32'd0);
    check({tag, " err"},       {31'd0, err},     32'd0);
    check({tag, " insn_addr"}, insn_addr,        32'd0);
    check({tag, " insn_din"},  insn_din,         32'd0);
    check({tag, " data_addr"}, data_addr,        32'd0);
    check({tag, " data_din"},  data_din,         32'd0);
  endtask

  task automatic run_insn_packet(input string tag, input int gap);
    int bi;
    int bd;
    bi = n_ins;
    bd = n_dat;
    pkt = '{8'h49, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02, 8'h00,
            8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_pkt(gap);
    // Last payload byte was sampled on the previous edge: pulse must be up now.
    check({tag, " last we latency"}, {31'd0, insn_we}, 32'd1);
    check({tag, " last addr live"},  insn_addr,        32'h0000_1004);
    idle(2);
    check({tag, " insn count"}, n_ins - bi, 32'd2);
    check({tag, " data count"}, n_dat - bd, 32'd0);
    check({tag, " w0 addr"}, ins_a[bi],     32'h0000_1000);
    check({tag, " w0 din"},  ins_d[bi],     32'h4433_2211);
    check({tag, " w1 addr"}, ins_a[bi + 1], 32'h0000_1004);
    check({tag, " w1 din"},  ins_d[bi + 1], 32'h8877_6655);
    check({tag, " busy after"}, {31'd0, busy}, 32'd0);
    check({tag, " addr held"}, insn_addr, 32'h0000_1004);
  endtask

  initial begin
    int bi;
    int bd;
    int be;

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    check_all_zero("reset");
    reset = 1'b0;
    idle(1);
    check("release no we", {31'd0, insn_we | data_we}, 32'd0);

    // Instruction packet with idle cycles between bytes.
    run_insn_packet("insn gapped", 1);

    // Data packet whose second word address wraps to zero.
    bi = n_ins;
    bd = n_dat;
    pkt = '{8'h44, 8'hFC, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00,
            8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_pkt(0);
    idle(2);
    check("wrap data count", n_dat - bd, 32'd2);
    check("wrap insn count", n_ins - bi, 32'd0);
    check("wrap w0 addr", dat_a[bd],     32'hFFFF_FFFC);
    check("wrap w0 din",  dat_d[bd],     32'h0403_0201);
    check("wrap w1 addr", dat_a[bd + 1], 32'h0000_0000);
    check("wrap w1 din",  dat_d[bd + 1], 32'h0807_0605);
    check("wrap busy", {31'd0, busy}, 32'd0);

    // Run command, ignored byte, then a zero-length packet.
    bi = n_ins;
    bd = n_dat;
    send_byte(8'h52);
    check("run set", {31'd0, run}, 32'd1);
    check("run set busy", {31'd0, busy}, 32'd0);
    send_byte(8'h41);
    idle(1);
    check("ignored run", {31'd0, run}, 32'd1);
    check("ignored busy", {31'd0, busy}, 32'd0);
    send_byte(8'h49);
    check("run cleared", {31'd0, run}, 32'd0);
    check("cmd busy", {31'd0, busy}, 32'd1);
    pkt = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_pkt(0);
    check("n0 busy", {31'd0, busy}, 32'd0);
    idle(2);
    check("n0 writes", (n_ins - bi) + (n_dat - bd), 32'd0);

    // Timeout: stall after two payload bytes, with a byte on the timeout cycle.
    bd = n_dat;
    be = n_err;
    pkt = '{8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB};
    send_pkt(0);
    idle(16);
    check("to before err", {31'd0, err}, 32'd0);
    check("to before busy", {31'd0, busy}, 32'd1);
    send_byte(8'h52);
    check("to err", {31'd0, err}, 32'd1);
    check("to busy", {31'd0, busy}, 32'd0);
    check("to dropped byte", {31'd0, run}, 32'd0);
    idle(1);
    check("to err single", {31'd0, err}, 32'd0);
    send_byte(8'h52);
    check("to run after", {31'd0, run}, 32'd1);
    idle(1);
    check("to err count", n_err - be, 32'd1);
    check("to no data we", n_dat - bd, 32'd0);

    // Reset in the middle of a one-word packet.
    bi = n_ins;
    pkt = '{8'h49, 8'h00, 8'h20, 8'h00, 8'h00, 8'h01, 8'h00, 8'hDE, 8'hAD};
    send_pkt(0);
    reset = 1'b1;
    #1;
    check_all_zero("mid reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);
    check("post reset we", {31'd0, insn_we | data_we}, 32'd0);
    send_byte(8'h41);
    check("post reset ignored", {31'd0, busy}, 32'd0);
    send_byte(8'hBE);
    send_byte(8'hEF);
    idle(1);
    check("post reset busy", {31'd0, busy}, 32'd0);
    check("post reset writes", n_ins - bi, 32'd0);

    // Same instruction packet with rx_valid on every cycle.
    run_insn_packet("insn b2b", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
